// File: rtl/data_mem_scan_if.sv
// CPU load/store port and min/max scan control/result bundle for data_mem_scan.
interface data_mem_scan_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 8
);
  logic [31:0]      adr;
  logic [WIDTH-1:0] write_data;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] read_data;

  logic             scan_start;
  logic [AW-1:0]    scan_base;
  logic [AW:0]      scan_len;
  logic             scan_max;
  logic             scan_signed;
  logic             scan_busy;
  logic             scan_done;
  logic [WIDTH-1:0] result_val;
  logic [31:0]      result_idx;

  modport master (
    output adr, write_data, mem_read, mem_write,
    output scan_start, scan_base, scan_len, scan_max, scan_signed,
    input  read_data, scan_busy, scan_done, result_val, result_idx
  );

  modport slave (
    input  adr, write_data, mem_read, mem_write,
    input  scan_start, scan_base, scan_len, scan_max, scan_signed,
    output read_data, scan_busy, scan_done, result_val, result_idx
  );
endinterface

// File: rtl/data_mem_scan.sv
// Word-addressed data memory with a one-word-per-cycle min/max range scanner.
// Scan completes len+1 edges after start; starts while busy or done are dropped.
module data_mem_scan #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input logic           clk,
  input logic           rst,
  data_mem_scan_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    ptr;
  logic [AW:0]      cnt;
  logic [AW:0]      len_q;
  logic             max_q;
  logic             signed_q;
  logic [WIDTH-1:0] best;
  logic [AW-1:0]    best_idx;
  logic [WIDTH-1:0] result_val;
  logic [AW-1:0]    result_idx;

  logic [AW-1:0]    cpu_idx;
  logic [WIDTH-1:0] cand;
  logic             cand_lt, cand_gt, take, last;

  wire unused_adr_bits = ^{bus.adr[31:AW+2], bus.adr[1:0]};

  assign cpu_idx = bus.adr[AW+1:2];

  // Both read ports are asynchronous so a same-edge store is never visible.
  assign bus.read_data = bus.mem_read ? mem[cpu_idx] : '0;
  assign cand          = mem[ptr];

  always_ff @(posedge clk) begin
    if (bus.mem_write) mem[cpu_idx] <= bus.write_data;
  end

  assign cand_lt = signed_q ? ($signed(cand) < $signed(best)) : (cand < best);
  assign cand_gt = signed_q ? ($signed(cand) > $signed(best)) : (cand > best);
  assign take    = (cnt == '0) || (max_q ? cand_gt : cand_lt);
  assign last    = (cnt == len_q - {{AW{1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.scan_start) state_nxt = (bus.scan_len == '0) ? DONE : SCAN;
      SCAN: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      cnt        <= '0;
      len_q      <= '0;
      max_q      <= 1'b0;
      signed_q   <= 1'b0;
      best       <= '0;
      best_idx   <= '0;
      result_val <= '0;
      result_idx <= '0;
    end else begin
      case (state)
        IDLE: if (bus.scan_start) begin
          ptr      <= bus.scan_base;
          cnt      <= '0;
          len_q    <= bus.scan_len;
          max_q    <= bus.scan_max;
          signed_q <= bus.scan_signed;
        end
        SCAN: begin
          if (take) begin
            best     <= cand;
            best_idx <= ptr;
          end
          ptr <= ptr + 1'b1;
          cnt <= cnt + 1'b1;
          if (last) begin
            result_val <= take ? cand : best;
            result_idx <= take ? ptr  : best_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.scan_busy  = (state == SCAN);
  assign bus.scan_done  = (state == DONE);
  assign bus.result_val = result_val;
  assign bus.result_idx = {{(32-AW){1'b0}}, result_idx};
endmodule

// File: tb/tb_data_mem_scan.sv
// Directed plus randomized bench for data_mem_scan against an array-based reference scan.
module tb_data_mem_scan;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_scan_if #(.WIDTH(WIDTH), .AW(AW)) ifc ();

  data_mem_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mm [DEPTH];
  logic [31:0] exp_val = '0;
  logic [31:0] exp_idx = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    ifc.adr        = 32'(idx) << 2;
    ifc.write_data = data;
    ifc.mem_write  = 1'b1;
    @(negedge clk);
    ifc.mem_write  = 1'b0;
    mm[idx] = data;
  endtask

  function automatic logic greater(input logic [31:0] a, input logic [31:0] b, input logic sg);
    return sg ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  // Reference: visit base..base+len-1 mod DEPTH, keep first strict winner.
  task automatic ref_scan(input int base, input int len, input logic mx, input logic sg);
    logic [31:0] bv;
    int bi;
    if (len == 0) return;
    bi = base % DEPTH;
    bv = mm[bi];
    for (int k = 1; k < len; k++) begin
      int i;
      i = (base + k) % DEPTH;
      if (mx ? greater(mm[i], bv, sg) : greater(bv, mm[i], sg)) begin
        bv = mm[i];
        bi = i;
      end
    end
    exp_val = bv;
    exp_idx = 32'(bi);
  endtask

  task automatic start_scan(input int base, input int len, input logic mx, input logic sg);
    @(negedge clk);
    ifc.scan_base   = AW'(base);
    ifc.scan_len    = (AW+1)'(len);
    ifc.scan_max    = mx;
    ifc.scan_signed = sg;
    ifc.scan_start  = 1'b1;
    @(negedge clk);
    ifc.scan_start  = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (!ifc.scan_done && edges < 600) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic do_scan(input string tag, input int base, input int len,
                         input logic mx, input logic sg);
    int edges;
    start_scan(base, len, mx, sg);
    wait_done(edges);
    ref_scan(base, len, mx, sg);
    chk({tag, "_latency"}, 32'(edges), (len == 0) ? 32'd1 : 32'(len + 1));
    chk({tag, "_val"}, ifc.result_val, exp_val);
    chk({tag, "_idx"}, ifc.result_idx, exp_idx);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(ifc.scan_done), 32'd0);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ifc.scan_done) n++;
    end
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    int edges;
    logic [31:0] v;

    ifc.adr = '0; ifc.write_data = '0; ifc.mem_read = 1'b0; ifc.mem_write = 1'b0;
    ifc.scan_start = 1'b0; ifc.scan_base = '0; ifc.scan_len = '0;
    ifc.scan_max = 1'b0; ifc.scan_signed = 1'b0;

    #20 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(ifc.scan_busy), 32'd0);
    chk("rst_done", 32'(ifc.scan_done), 32'd0);
    chk("rst_val",  ifc.result_val, 32'd0);
    chk("rst_idx",  ifc.result_idx, 32'd0);

    for (int i = 0; i < DEPTH; i++) cpu_write(i, 32'd0);

    cpu_write(2, 32'h1234);
    ifc.adr = 32'h8; ifc.mem_read = 1'b1;
    #1 chk("load_0x8", ifc.read_data, 32'h1234);
    ifc.mem_read = 1'b0;
    #1 chk("load_disabled", ifc.read_data, 32'd0);

    // Unsigned min with a tie at value 3.
    cpu_write(10, 7); cpu_write(11, 3); cpu_write(12, 9); cpu_write(13, 3); cpu_write(14, 5);
    do_scan("umin", 10, 5, 1'b0, 1'b0);
    chk("umin_val_const", ifc.result_val, 32'd3);
    chk("umin_idx_const", ifc.result_idx, 32'd11);

    cpu_write(0, 32'hFFFF_FFFF); cpu_write(1, 32'd2); cpu_write(2, 32'h8000_0000);
    do_scan("smax", 0, 3, 1'b1, 1'b1);
    chk("smax_val_const", ifc.result_val, 32'd2);
    chk("smax_idx_const", ifc.result_idx, 32'd1);
    do_scan("umax", 0, 3, 1'b1, 1'b0);
    chk("umax_val_const", ifc.result_val, 32'hFFFF_FFFF);
    chk("umax_idx_const", ifc.result_idx, 32'd0);

    cpu_write(254, 50); cpu_write(255, 40); cpu_write(0, 32'hFFFF_FFFB); cpu_write(1, 60);
    do_scan("wrap", 254, 4, 1'b0, 1'b1);
    chk("wrap_val_const", ifc.result_val, 32'hFFFF_FFFB);
    chk("wrap_idx_const", ifc.result_idx, 32'd0);

    do_scan("len0", 7, 0, 1'b1, 1'b0);
    chk("len0_val_kept", ifc.result_val, 32'hFFFF_FFFB);

    // Stores racing the scanner over words 20..24.
    cpu_write(20, 10); cpu_write(21, 20); cpu_write(22, 30); cpu_write(23, 40); cpu_write(24, 50);
    start_scan(20, 5, 1'b0, 1'b0);
    chk("conc_busy", 32'(ifc.scan_busy), 32'd1);
    @(negedge clk);
    ifc.scan_start = 1'b1; ifc.scan_base = 8'd0; ifc.scan_len = 9'd3;
    @(negedge clk);
    ifc.scan_start = 1'b0;
    ifc.adr = 32'd24 << 2; ifc.write_data = 32'd1; ifc.mem_write = 1'b1;
    mm[24] = 32'd1;
    @(negedge clk);
    ifc.adr = 32'd23 << 2; ifc.write_data = 32'd0;
    ref_scan(20, 5, 1'b0, 1'b0);
    mm[23] = 32'd0;
    @(negedge clk);
    ifc.mem_write = 1'b0;
    @(negedge clk);
    chk("conc_done", 32'(ifc.scan_done), 32'd1);
    chk("conc_val", ifc.result_val, exp_val);
    chk("conc_idx", ifc.result_idx, exp_idx);
    chk("conc_val_const", ifc.result_val, 32'd1);
    count_dones("conc_no_extra_done", 8);
    ifc.adr = 32'd23 << 2; ifc.mem_read = 1'b1;
    #1 chk("conc_store_landed", ifc.read_data, 32'd0);
    ifc.mem_read = 1'b0;

    // Reset in the third scan cycle.
    start_scan(30, 8, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(ifc.scan_busy), 32'd0);
    chk("mrst_done", 32'(ifc.scan_done), 32'd0);
    chk("mrst_val",  ifc.result_val, 32'd0);
    chk("mrst_idx",  ifc.result_idx, 32'd0);
    exp_val = '0; exp_idx = '0;
    @(negedge clk);
    rst = 1'b0;
    count_dones("mrst_no_done", 10);
    do_scan("post_rst", 10, 5, 1'b1, 1'b0);

    for (int it = 0; it < 24; it++) begin
      int base, len;
      for (int w = 0; w < 8; w++) begin
        case ($urandom_range(0, 2))
          0: v = $urandom;
          1: v = $urandom_range(0, 20);
          default: v = 32'(-$urandom_range(1, 20));
        endcase
        cpu_write($urandom_range(0, DEPTH-1), v);
      end
      base = $urandom_range(0, DEPTH-1);
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = DEPTH;
        default: len = $urandom_range(1, 40);
      endcase
      do_scan($sformatf("rnd%0d", it), base, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
